// File: rtl/maquina_estados_ascensor.sv
// Four-floor elevator controller with a SCAN (up/down sweep) state machine.
// Cabin and hall calls are latched until served. Floor-to-floor travel and
// door dwell are timed by a shared counter. A 4-digit multiplexed 7-segment
// display shows the floor, the direction and the door state.
// Ports:
//   clk            system clock, rising edge
//   rst            synchronous active-high reset
//   piso1..piso4   cabin buttons for floors 1..4 (level)
//   S1,S2,S3       hall "up" calls at floors 1..3
//   B2,B3,B4       hall "down" calls at floors 2..4
//   DISPLAY[7:0]   segments {dp,g,f,e,d,c,b,a}, active-low, registered
//   ANODES[3:0]    digit enables, active-low, registered
module maquina_estados_ascensor #(
  parameter int TRAVEL_CYCLES  = 50_000_000,
  parameter int DOOR_CYCLES    = 100_000_000,
  parameter int REFRESH_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       piso1,
  input  logic       piso2,
  input  logic       piso3,
  input  logic       piso4,
  input  logic       S1,
  input  logic       S2,
  input  logic       S3,
  input  logic       B2,
  input  logic       B3,
  input  logic       B4,
  output logic [7:0] DISPLAY,
  output logic [3:0] ANODES
);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

  localparam int TMAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int RW   = $clog2(REFRESH_CYCLES + 1);
  localparam logic [TW-1:0] TRAVEL_LAST  = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] DOOR_LAST    = TW'(DOOR_CYCLES - 1);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);

  state_t        state, state_n;
  dir_t          dir, dir_n;
  logic [1:0]    floor, floor_n, fn;   // floor index 0..3 = floors 1..4
  logic [TW-1:0] tmr, tmr_n;
  logic [3:0]    car, up, dn, car_n, up_n, dn_n;
  logic [3:0]    clr_car, clr_up, clr_dn, pend;
  logic [RW-1:0] ref_cnt, ref_n;
  logic [1:0]    digit, digit_n;
  logic [7:0]    seg_n;

  // Calls strictly above / below floor f.
  function automatic logic [3:0] above_m(input logic [1:0] f);
    return 4'b1110 << f;
  endfunction
  function automatic logic [3:0] below_m(input logic [1:0] f);
    return ~(4'b1111 << f);
  endfunction

  assign pend = car | up | dn;

  always_comb begin
    state_n = state;
    dir_n   = dir;
    floor_n = floor;
    tmr_n   = tmr;
    fn      = floor;
    clr_car = '0;
    clr_up  = '0;
    clr_dn  = '0;
    case (state)
      IDLE: begin
        dir_n = DIR_NONE;
        tmr_n = '0;
        if (pend[floor]) begin
          // No travel direction: every call at this floor is served.
          state_n        = DOOR_OPEN;
          clr_car[floor] = 1'b1;
          clr_up[floor]  = 1'b1;
          clr_dn[floor]  = 1'b1;
        end else if (|(pend & above_m(floor))) begin
          state_n = MOVE_UP;
          dir_n   = DIR_UP;
        end else if (|(pend & below_m(floor))) begin
          state_n = MOVE_DOWN;
          dir_n   = DIR_DOWN;
        end
      end
      MOVE_UP: begin
        if (tmr == TRAVEL_LAST) begin
          fn      = (floor == 2'd3) ? floor : floor + 2'd1;
          floor_n = fn;
          tmr_n   = '0;
          if (car[fn] | up[fn] | ~(|(pend & above_m(fn)))) begin
            state_n     = DOOR_OPEN;
            clr_car[fn] = 1'b1;
            clr_up[fn]  = 1'b1;
            // End of the upward sweep: the down call here is served too.
            if (~(|(pend & above_m(fn)))) begin
              clr_dn[fn] = 1'b1;
              dir_n      = DIR_NONE;
            end
          end
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      MOVE_DOWN: begin
        if (tmr == TRAVEL_LAST) begin
          fn      = (floor == 2'd0) ? floor : floor - 2'd1;
          floor_n = fn;
          tmr_n   = '0;
          if (car[fn] | dn[fn] | ~(|(pend & below_m(fn)))) begin
            state_n     = DOOR_OPEN;
            clr_car[fn] = 1'b1;
            clr_dn[fn]  = 1'b1;
            if (~(|(pend & below_m(fn)))) begin
              clr_up[fn] = 1'b1;
              dir_n      = DIR_NONE;
            end
          end
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      DOOR_OPEN: begin
        if (tmr == DOOR_LAST) begin
          tmr_n = '0;
          // Anything pressed for this floor during the dwell is dropped.
          clr_car[floor] = 1'b1;
          clr_up[floor]  = 1'b1;
          clr_dn[floor]  = 1'b1;
          // Prefer the current sweep; with no direction, up wins.
          if (dir != DIR_DOWN && |(pend & above_m(floor))) begin
            state_n = MOVE_UP;
            dir_n   = DIR_UP;
          end else if (|(pend & below_m(floor))) begin
            state_n = MOVE_DOWN;
            dir_n   = DIR_DOWN;
          end else if (|(pend & above_m(floor))) begin
            state_n = MOVE_UP;
            dir_n   = DIR_UP;
          end else begin
            state_n = IDLE;
            dir_n   = DIR_NONE;
          end
        end else begin
          tmr_n = tmr + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A button held in the same cycle as a clear keeps its call.
  assign car_n = (car & ~clr_car) | {piso4, piso3, piso2, piso1};
  assign up_n  = (up  & ~clr_up)  | {1'b0, S3, S2, S1};
  assign dn_n  = (dn  & ~clr_dn)  | {B4, B3, B2, 1'b0};

  // The display is decoded from next-state values so the registered outputs
  // always match the state registers in the same cycle.
  always_comb begin
    ref_n   = ref_cnt + 1'b1;
    digit_n = digit;
    if (ref_cnt == REFRESH_LAST) begin
      ref_n   = '0;
      digit_n = digit + 2'd1;
    end
    seg_n = 8'hFF;
    case (digit_n)
      2'd0: begin
        case (floor_n)
          2'd0:    seg_n = 8'hF9;
          2'd1:    seg_n = 8'hA4;
          2'd2:    seg_n = 8'hB0;
          default: seg_n = 8'h99;
        endcase
      end
      2'd1: begin
        case (dir_n)
          DIR_UP:   seg_n = 8'h92;
          DIR_DOWN: seg_n = 8'h83;
          default:  seg_n = 8'hBF;
        endcase
      end
      2'd2:    seg_n = (state_n == DOOR_OPEN) ? 8'h88 : 8'hC6;
      default: seg_n = 8'hFF;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dir     <= DIR_NONE;
      floor   <= 2'd0;
      tmr     <= '0;
      car     <= '0;
      up      <= '0;
      dn      <= '0;
      ref_cnt <= '0;
      digit   <= 2'd0;
      ANODES  <= 4'b1110;
      DISPLAY <= 8'hF9;
    end else begin
      state   <= state_n;
      dir     <= dir_n;
      floor   <= floor_n;
      tmr     <= tmr_n;
      car     <= car_n;
      up      <= up_n;
      dn      <= dn_n;
      ref_cnt <= ref_n;
      digit   <= digit_n;
      ANODES  <= ~(4'b0001 << digit_n);
      DISPLAY <= seg_n;
    end
  end

endmodule

// File: tb/tb_maquina_estados_ascensor.sv
// Directed bench for the elevator controller (TRAVEL=4, DOOR=3, REFRESH=2).
// k counts clock edges since reset release; the lit digit is (k/2)%4.
module tb_maquina_estados_ascensor;

  localparam int ST_IDLE = 0, ST_MU = 1, ST_MD = 2, ST_DO = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic piso1 = 0, piso2 = 0, piso3 = 0, piso4 = 0;
  logic S1 = 0, S2 = 0, S3 = 0, B2 = 0, B3 = 0, B4 = 0;
  logic [7:0] DISPLAY;
  logic [3:0] ANODES;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;

  maquina_estados_ascensor #(
    .TRAVEL_CYCLES(4), .DOOR_CYCLES(3), .REFRESH_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst),
    .piso1(piso1), .piso2(piso2), .piso3(piso3), .piso4(piso4),
    .S1(S1), .S2(S2), .S3(S3), .B2(B2), .B3(B3), .B4(B4),
    .DISPLAY(DISPLAY), .ANODES(ANODES)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    k = 0;
  endtask

  initial begin
    // 1: reset state
    do_reset();
    chk("rst_state", 32'(dut.state), ST_IDLE);
    chk("rst_floor", 32'(dut.floor), 0);
    chk("rst_calls", 32'({dut.car, dut.up, dut.dn}), 0);
    chk("rst_an", 32'(ANODES), 32'hE);
    chk("rst_seg", 32'(DISPLAY), 32'hF9);

    // 2: single cabin call to floor 2
    piso2 = 1; tick(); piso2 = 0;
    chk("t2_car_latch", 32'(dut.car), 32'b0010);
    tick();
    chk("t2_move", 32'(dut.state), ST_MU);
    repeat (3) tick();
    chk("t2_still_moving", 32'(dut.state), ST_MU);
    chk("t2_floor_before", 32'(dut.floor), 0);
    tick();
    chk("t2_door", 32'(dut.state), ST_DO);
    chk("t2_floor", 32'(dut.floor), 1);
    chk("t2_car_clr", 32'(dut.car), 0);
    repeat (2) tick();
    chk("t2_door_hold", 32'(dut.state), ST_DO);
    tick();
    chk("t2_idle", 32'(dut.state), ST_IDLE);
    chk("t2_an0", 32'(ANODES), 32'hE);
    chk("t2_seg_a4", 32'(DISPLAY), 32'hA4);

    // 3: call at the current floor opens the door without moving
    do_reset();
    piso1 = 1; tick(); piso1 = 0;
    tick();
    chk("t3_door", 32'(dut.state), ST_DO);
    chk("t3_floor", 32'(dut.floor), 0);
    chk("t3_car_clr", 32'(dut.car), 0);
    repeat (2) tick();
    chk("t3_an2", 32'(ANODES), 32'hB);
    chk("t3_seg_open", 32'(DISPLAY), 32'h88);
    tick();
    chk("t3_idle", 32'(dut.state), ST_IDLE);
    chk("t3_seg_closed", 32'(DISPLAY), 32'hC6);

    // 4: up sweep skips the down call at 3, then comes back for it
    do_reset();
    piso4 = 1; B3 = 1; tick(); piso4 = 0; B3 = 0;
    tick();
    chk("t4_move", 32'(dut.state), ST_MU);
    repeat (8) tick();
    chk("t4_pass3_state", 32'(dut.state), ST_MU);
    chk("t4_pass3_floor", 32'(dut.floor), 2);
    repeat (4) tick();
    chk("t4_door4", 32'(dut.state), ST_DO);
    chk("t4_floor4", 32'(dut.floor), 3);
    chk("t4_dn_kept", 32'(dut.dn), 32'b0100);
    chk("t4_dir_none", 32'(dut.dir), 0);
    repeat (3) tick();
    chk("t4_reverse", 32'(dut.state), ST_MD);
    tick();
    chk("t4_an1", 32'(ANODES), 32'hD);
    chk("t4_seg_down", 32'(DISPLAY), 32'h83);
    repeat (3) tick();
    chk("t4_door3", 32'(dut.state), ST_DO);
    chk("t4_floor3", 32'(dut.floor), 2);
    chk("t4_dn_clr", 32'(dut.dn), 0);
    repeat (3) tick();
    chk("t4_idle", 32'(dut.state), ST_IDLE);

    // 5: hall up at 2 plus cabin 3: two stops on one sweep
    do_reset();
    S2 = 1; piso3 = 1; tick(); S2 = 0; piso3 = 0;
    tick();
    chk("t5_move", 32'(dut.state), ST_MU);
    tick();
    chk("t5_an1", 32'(ANODES), 32'hD);
    chk("t5_seg_up", 32'(DISPLAY), 32'h92);
    repeat (3) tick();
    chk("t5_door2", 32'(dut.state), ST_DO);
    chk("t5_floor2", 32'(dut.floor), 1);
    chk("t5_up_clr", 32'(dut.up), 0);
    chk("t5_car_left", 32'(dut.car), 32'b0100);
    repeat (3) tick();
    chk("t5_continue", 32'(dut.state), ST_MU);
    repeat (4) tick();
    chk("t5_door3", 32'(dut.state), ST_DO);
    chk("t5_floor3", 32'(dut.floor), 2);
    repeat (3) tick();
    chk("t5_idle", 32'(dut.state), ST_IDLE);
    repeat (2) tick();
    chk("t5_an1_idle", 32'(ANODES), 32'hD);
    chk("t5_seg_none", 32'(DISPLAY), 32'hBF);

    // 6: reset in the middle of a move, then the digit scan
    do_reset();
    piso4 = 1; tick(); piso4 = 0;
    tick();
    repeat (5) tick();
    chk("t6_pre_state", 32'(dut.state), ST_MU);
    chk("t6_pre_floor", 32'(dut.floor), 1);
    rst = 1'b1; tick();
    chk("t6_state", 32'(dut.state), ST_IDLE);
    chk("t6_floor", 32'(dut.floor), 0);
    chk("t6_calls", 32'({dut.car, dut.up, dut.dn}), 0);
    chk("t6_an", 32'(ANODES), 32'hE);
    chk("t6_seg", 32'(DISPLAY), 32'hF9);
    rst = 1'b0; k = 0;
    tick();
    chk("t6_k1_an", 32'(ANODES), 32'hE);
    tick();
    chk("t6_k2_an", 32'(ANODES), 32'hD);
    chk("t6_k2_seg", 32'(DISPLAY), 32'hBF);
    repeat (2) tick();
    chk("t6_k4_an", 32'(ANODES), 32'hB);
    chk("t6_k4_seg", 32'(DISPLAY), 32'hC6);
    repeat (2) tick();
    chk("t6_k6_an", 32'(ANODES), 32'h7);
    chk("t6_k6_seg", 32'(DISPLAY), 32'hFF);
    repeat (2) tick();
    chk("t6_k8_an", 32'(ANODES), 32'hE);
    chk("t6_k8_seg", 32'(DISPLAY), 32'hF9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
